// File: rtl/alu_pkg.sv
// Shared opcode, funct and ALU-code constants plus decode result types.
// Pure definitions: no latency, no flow control.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [5:0] ALUC_ADD  = 6'b100000;
  localparam logic [5:0] ALUC_ADDU = 6'b100001;
  localparam logic [5:0] ALUC_AND  = 6'b100100;
  localparam logic [5:0] ALUC_OR   = 6'b100101;
  localparam logic [5:0] ALUC_XOR  = 6'b100110;
  localparam logic [5:0] ALUC_SLT  = 6'b101010;
  localparam logic [5:0] ALUC_SLTU = 6'b101011;
  localparam logic [5:0] ALUC_LUI  = 6'b001111;

  typedef enum logic [1:0] {ASEL_ZERO, ASEL_RS, ASEL_SHAMT} asel_e;
  typedef enum logic [1:0] {BSEL_ZERO, BSEL_RT, BSEL_SIMM, BSEL_ZIMM} bsel_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] aluc;
    asel_e      a_sel;
    bsel_e      b_sel;
    logic [4:0] dest;
    logic       illegal;
  } dec_t;

  // Register 0 is hardwired; an in-flight writeback beats the regfile read.
  function automatic logic [31:0] src_value(input logic [4:0] addr, input logic [31:0] rf_data,
                                            input logic wb_en, input logic [4:0] wb_addr,
                                            input logic [31:0] wb_data);
    if (addr == 5'd0)                    return 32'd0;
    else if (wb_en && (wb_addr == addr)) return wb_data;
    else                                 return rf_data;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS word decode into ALU code, operand selects and destination.
// Zero latency; no flow control.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];

  always_comb begin
    dec_o.rs      = instr_i[25:21];
    dec_o.rt      = instr_i[20:16];
    dec_o.aluc    = ALUC_ADDU;
    dec_o.a_sel   = ASEL_ZERO;
    dec_o.b_sel   = BSEL_ZERO;
    dec_o.dest    = 5'd0;
    dec_o.illegal = 1'b1;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
        FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV: begin
          dec_o.aluc    = fn;
          dec_o.a_sel   = ASEL_RS;
          dec_o.b_sel   = BSEL_RT;
          dec_o.dest    = instr_i[15:11];
          dec_o.illegal = 1'b0;
        end
        FN_SLL, FN_SRL, FN_SRA: begin
          dec_o.aluc    = fn;
          dec_o.a_sel   = ASEL_SHAMT;
          dec_o.b_sel   = BSEL_RT;
          dec_o.dest    = instr_i[15:11];
          dec_o.illegal = 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
          dec_o.a_sel   = ASEL_RS;
          dec_o.dest    = instr_i[20:16];
          dec_o.illegal = 1'b0;
          case (op)
            OP_ADDI:  begin dec_o.aluc = ALUC_ADD;  dec_o.b_sel = BSEL_SIMM; end
            OP_ADDIU: begin dec_o.aluc = ALUC_ADDU; dec_o.b_sel = BSEL_SIMM; end
            OP_SLTI:  begin dec_o.aluc = ALUC_SLT;  dec_o.b_sel = BSEL_SIMM; end
            OP_SLTIU: begin dec_o.aluc = ALUC_SLTU; dec_o.b_sel = BSEL_SIMM; end
            OP_ANDI:  begin dec_o.aluc = ALUC_AND;  dec_o.b_sel = BSEL_ZIMM; end
            OP_ORI:   begin dec_o.aluc = ALUC_OR;   dec_o.b_sel = BSEL_ZIMM; end
            default:  begin dec_o.aluc = ALUC_XOR;  dec_o.b_sel = BSEL_ZIMM; end
          endcase
        end
        OP_LUI: begin
          dec_o.aluc    = ALUC_LUI;
          dec_o.a_sel   = ASEL_ZERO;
          dec_o.b_sel   = BSEL_ZIMM;
          dec_o.dest    = instr_i[20:16];
          dec_o.illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decodes an instruction, fetches forwarded operands and holds one ALU op for issue.
// One-cycle accept-to-valid latency; in_ready = !out_valid || out_ready.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [5:0]  aluc,
  output logic [4:0]  dest,
  output logic        illegal
);

  dec_t        dec;
  logic [31:0] rs_val, rt_val, a_new, b_new;
  logic [4:0]  a_tag_new, b_tag_new;
  logic        accept;

  logic        valid_q, valid_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [5:0]  aluc_q, aluc_d;
  logic [4:0]  dest_q, dest_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  a_tag_q, a_tag_d, b_tag_q, b_tag_d;

  alu_decode u_decode (
    .instr_i (instr),
    .dec_o   (dec)
  );

  assign rs_addr  = dec.rs;
  assign rt_addr  = dec.rt;
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign rs_val = src_value(rs_addr, rs_data, wb_en, wb_addr, wb_data);
  assign rt_val = src_value(rt_addr, rt_data, wb_en, wb_addr, wb_data);

  always_comb begin
    case (dec.a_sel)
      ASEL_RS:    a_new = rs_val;
      ASEL_SHAMT: a_new = {27'd0, instr[10:6]};
      default:    a_new = 32'd0;
    endcase
    case (dec.b_sel)
      BSEL_RT:   b_new = rt_val;
      BSEL_SIMM: b_new = {{16{instr[15]}}, instr[15:0]};
      BSEL_ZIMM: b_new = {16'd0, instr[15:0]};
      default:   b_new = 32'd0;
    endcase
  end

  // Tag 0 marks an operand that must never be refreshed by writeback.
  assign a_tag_new = (dec.a_sel == ASEL_RS) ? rs_addr : 5'd0;
  assign b_tag_new = (dec.b_sel == BSEL_RT) ? rt_addr : 5'd0;

  always_comb begin
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    aluc_d    = aluc_q;
    dest_d    = dest_q;
    illegal_d = illegal_q;
    a_tag_d   = a_tag_q;
    b_tag_d   = b_tag_q;
    if (accept) begin
      valid_d   = 1'b1;
      a_d       = a_new;
      b_d       = b_new;
      aluc_d    = dec.aluc;
      dest_d    = dec.dest;
      illegal_d = dec.illegal;
      a_tag_d   = a_tag_new;
      b_tag_d   = b_tag_new;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q && wb_en && (wb_addr != 5'd0)) begin
      if (wb_addr == a_tag_q) a_d = wb_data;
      if (wb_addr == b_tag_q) b_d = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      aluc_q    <= 6'd0;
      dest_q    <= 5'd0;
      illegal_q <= 1'b0;
      a_tag_q   <= 5'd0;
      b_tag_q   <= 5'd0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluc_q    <= aluc_d;
      dest_q    <= dest_d;
      illegal_q <= illegal_d;
      a_tag_q   <= a_tag_d;
      b_tag_q   <= b_tag_d;
    end
  end

  assign out_valid = valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign aluc      = aluc_q;
  assign dest      = dest_q;
  assign illegal   = illegal_q;

endmodule
